// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: per-stage tracking entry,
// forward-select encoding and a constant-foldable clog2.
package hazard_pkg;

  localparam int FWD_RF       = 0;
  // Widest register number any instance may use; narrower numbers are zero-extended.
  localparam int MAX_REG_BITS = 16;

  typedef struct packed {
    logic                    valid;
    logic [MAX_REG_BITS-1:0] dst;
    logic                    wr;
    logic                    load;
  } stage_entry_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// One source operand against every tracked stage: youngest-match priority
// encoder producing the forward select and the load-use stall request.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter  int REG_COUNT_BITS   = 5,
  parameter  int DEPTH            = 3,
  parameter  int LOAD_READY_STAGE = 2,
  localparam int FWD_SEL_BITS     = clog2(DEPTH)
) (
  input  logic                      i_issue_valid,
  input  logic                      i_used,
  input  logic [REG_COUNT_BITS-1:0] i_src,
  input  stage_entry_t [DEPTH-1:0]  i_entries,
  output logic [FWD_SEL_BITS-1:0]   o_fwd_sel,
  output logic                      o_load_stall
);

  logic [DEPTH-1:0] w_hit;

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      w_hit[j] = i_issue_valid && i_used && (i_src != '0) &&
                 i_entries[j].valid && i_entries[j].wr &&
                 (i_entries[j].dst == MAX_REG_BITS'(i_src));
    end
  end

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; without this the tool would infer a latch.
  always_comb begin
    o_fwd_sel    = FWD_SEL_BITS'(FWD_RF);
    o_load_stall = 1'b0;
    // Scan oldest to youngest so the lowest matching stage is written last.
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (w_hit[j]) begin
        // The oldest stage writes the write-first register file this cycle.
        o_fwd_sel    = (j <= DEPTH - 2) ? FWD_SEL_BITS'(j + 1) : FWD_SEL_BITS'(FWD_RF);
        o_load_stall = i_entries[j].load && (j + 1 < LOAD_READY_STAGE);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Post-decode hazard tracker: shifts producer info through DEPTH stages and
// issues the load-use stall plus registered per-operand forward selects.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int REG_COUNT_BITS   = 5,
  parameter  int DEPTH            = 3,
  parameter  int NUM_SRC          = 2,
  parameter  int LOAD_READY_STAGE = 2,
  localparam int FWD_SEL_BITS     = clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              issue_valid,
  input  logic [NUM_SRC*REG_COUNT_BITS-1:0] issue_src,
  input  logic [NUM_SRC-1:0]                issue_src_used,
  input  logic [REG_COUNT_BITS-1:0]         issue_dst,
  input  logic                              issue_reg_write,
  input  logic                              issue_is_load,
  input  logic                              flush,
  input  logic                              hold,
  output logic                              stall,
  output logic [NUM_SRC*FWD_SEL_BITS-1:0]   fwd_sel,
  output logic [DEPTH-1:0]                  stage_valid
);

  stage_entry_t [DEPTH-1:0]          r_stage;
  logic [NUM_SRC*FWD_SEL_BITS-1:0]   r_fwd_sel;
  logic [NUM_SRC*FWD_SEL_BITS-1:0]   w_fwd_sel;
  logic [NUM_SRC-1:0]                w_load_stall;
  logic                              w_accept;
  stage_entry_t                      w_new_entry;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    hazard_src_match #(
      .REG_COUNT_BITS   (REG_COUNT_BITS),
      .DEPTH            (DEPTH),
      .LOAD_READY_STAGE (LOAD_READY_STAGE)
    ) u_match (
      .i_issue_valid (issue_valid),
      .i_used        (issue_src_used[g]),
      .i_src         (issue_src[g*REG_COUNT_BITS +: REG_COUNT_BITS]),
      .i_entries     (r_stage),
      .o_fwd_sel     (w_fwd_sel[g*FWD_SEL_BITS +: FWD_SEL_BITS]),
      .o_load_stall  (w_load_stall[g])
    );
  end

  // flush and hold both release fetch, so either one masks the stall.
  assign stall    = (|w_load_stall) && !flush && !hold && !reset;
  assign w_accept = issue_valid && !stall && !flush;

  always_comb begin
    w_new_entry       = '0;
    w_new_entry.valid = 1'b1;
    w_new_entry.dst   = MAX_REG_BITS'(issue_dst);
    w_new_entry.wr    = issue_reg_write && (issue_dst != '0);
    w_new_entry.load  = issue_is_load;
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value and the shift order is irrelevant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage   <= '0;
      r_fwd_sel <= '0;
    end else if (!hold) begin
      for (int j = DEPTH - 1; j >= 1; j--) begin
        r_stage[j] <= r_stage[j-1];
      end
      r_stage[0] <= w_accept ? w_new_entry : '0;
      r_fwd_sel  <= w_accept ? w_fwd_sel : '0;
    end
  end

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      stage_valid[j] = r_stage[j].valid;
    end
  end

  assign fwd_sel = r_fwd_sel;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed vector table, hold/DEPTH=4 sequences, and a
// random run against an instruction-queue reference model.
module tb_hazard_scoreboard;

  localparam int RB    = 5;
  localparam int DEPTH = 3;
  localparam int NSRC  = 2;
  localparam int LRS   = 2;

  logic       clk = 1'b0;
  logic       reset, issue_valid, issue_reg_write, issue_is_load, flush, hold;
  logic [9:0] issue_src;
  logic [1:0] issue_src_used;
  logic [4:0] issue_dst;
  logic       stall, stall4;
  logic [3:0] fwd_sel, fwd_sel4;
  logic [2:0] stage_valid;
  logic [3:0] stage_valid4;

  always #5 clk = ~clk;

  hazard_scoreboard u_dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_src(issue_src),
    .issue_src_used(issue_src_used), .issue_dst(issue_dst),
    .issue_reg_write(issue_reg_write), .issue_is_load(issue_is_load),
    .flush(flush), .hold(hold), .stall(stall), .fwd_sel(fwd_sel),
    .stage_valid(stage_valid)
  );

  hazard_scoreboard #(.DEPTH(4), .LOAD_READY_STAGE(3)) u_dut4 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_src(issue_src),
    .issue_src_used(issue_src_used), .issue_dst(issue_dst),
    .issue_reg_write(issue_reg_write), .issue_is_load(issue_is_load),
    .flush(flush), .hold(hold), .stall(stall4), .fwd_sel(fwd_sel4),
    .stage_valid(stage_valid4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of accepted instructions with their current stage.
  typedef struct {
    logic [4:0] dst;
    bit         writes;
    bit         load;
    int         stage;
  } inst_t;

  inst_t      m_q[$];
  logic [1:0] m_fwd[NSRC];

  function automatic int youngest(input logic [4:0] src, output bit is_load);
    int best;
    best    = -1;
    is_load = 1'b0;
    foreach (m_q[i]) begin
      if (m_q[i].writes && m_q[i].dst == src && (best < 0 || m_q[i].stage < best)) begin
        best    = m_q[i].stage;
        is_load = m_q[i].load;
      end
    end
    return best;
  endfunction

  function automatic logic [4:0] src_of(input int i);
    logic [9:0] s;
    s = issue_src;
    return s[i*RB +: RB];
  endfunction

  function automatic bit model_stall();
    bit ld;
    int s;
    if (reset || flush || hold || !issue_valid) return 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (issue_src_used[i]) begin
        s = youngest(src_of(i), ld);
        if (s >= 0 && ld && s + 1 < LRS) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [2:0] model_sv();
    logic [2:0] v;
    v = '0;
    foreach (m_q[i]) v[m_q[i].stage] = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] model_fwd();
    return {m_fwd[1], m_fwd[0]};
  endfunction

  task automatic model_edge(input bit st);
    logic [1:0] nf[NSRC];
    inst_t      nq[$];
    bit         ld;
    int         s;
    if (reset) begin
      m_q.delete();
      foreach (m_fwd[i]) m_fwd[i] = 2'd0;
      return;
    end
    if (hold) return;
    for (int i = 0; i < NSRC; i++) begin
      nf[i] = 2'd0;
      if (issue_src_used[i]) begin
        s = youngest(src_of(i), ld);
        if (s >= 0 && s <= DEPTH - 2) nf[i] = 2'(s + 1);
      end
    end
    foreach (m_q[i]) begin
      if (m_q[i].stage + 1 < DEPTH) begin
        inst_t t = m_q[i];
        t.stage++;
        nq.push_back(t);
      end
    end
    m_q = nq;
    if (issue_valid && !st && !flush) begin
      inst_t n;
      n.dst    = issue_dst;
      n.writes = issue_reg_write && (issue_dst != 5'd0);
      n.load   = issue_is_load;
      n.stage  = 0;
      m_q.push_back(n);
      foreach (m_fwd[i]) m_fwd[i] = nf[i];
    end else begin
      foreach (m_fwd[i]) m_fwd[i] = 2'd0;
    end
  endtask

  typedef struct {
    bit         v;
    logic [4:0] s0, s1;
    logic [1:0] used;
    logic [4:0] dst;
    bit         wr, ld, fl, hd;
    bit         e_stall;
    logic [3:0] e_fwd;
    logic [2:0] e_sv;
  } vec_t;

  function automatic vec_t mk(input bit v, input logic [4:0] s0, input logic [4:0] s1,
                              input logic [1:0] used, input logic [4:0] dst,
                              input bit wr, input bit ld, input bit fl, input bit hd,
                              input bit es, input logic [3:0] ef, input logic [2:0] esv);
    vec_t r;
    r.v = v; r.s0 = s0; r.s1 = s1; r.used = used; r.dst = dst;
    r.wr = wr; r.ld = ld; r.fl = fl; r.hd = hd;
    r.e_stall = es; r.e_fwd = ef; r.e_sv = esv;
    return r;
  endfunction

  function automatic vec_t idle(input logic [2:0] esv);
    return mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'h0, esv);
  endfunction

  // Drive at the falling edge; outputs are read 1 time unit later.
  task automatic apply(input vec_t v);
    @(negedge clk);
    issue_valid     = v.v;
    issue_src       = {v.s1, v.s0};
    issue_src_used  = v.used;
    issue_dst       = v.dst;
    issue_reg_write = v.wr;
    issue_is_load   = v.ld;
    flush           = v.fl;
    hold            = v.hd;
    #1;
  endtask

  task automatic tick();
    bit st;
    st = model_stall();
    @(posedge clk);
    model_edge(st);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(mk(1, 3, 3, 2'b11, 3, 1, 1, 0, 0, 0, 0, 0));
      tick();
    end
    reset = 1'b0;
  endtask

  vec_t       tbl[$];
  vec_t       hseq[$];
  logic [3:0] ref_fwd[8];
  logic [2:0] ref_sv[8];

  initial begin
    reset = 1'b1;
    apply(idle(0));

    // Reset with a valid, matching instruction on decode.
    for (int i = 0; i < 2; i++) begin
      apply(mk(1, 3, 3, 2'b11, 3, 1, 1, 0, 0, 0, 0, 0));
      check("reset stall", stall, 0);
      tick();
      check("reset stage_valid", stage_valid, 0);
      check("reset fwd_sel", fwd_sel, 0);
    end
    reset = 1'b0;

    // ALU chain, gaps, load-use, flush, r0, unused operand, youngest match.
    tbl.push_back(mk(1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0, 4'h0, 3'b001));
    tbl.push_back(mk(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0, 4'h1, 3'b011));
    tbl.push_back(idle(3'b110));
    tbl.push_back(idle(3'b100));
    tbl.push_back(idle(3'b000));
    tbl.push_back(mk(1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0, 4'h0, 3'b001));
    tbl.push_back(idle(3'b010));
    tbl.push_back(mk(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0, 4'h2, 3'b101));
    tbl.push_back(idle(3'b010));
    tbl.push_back(idle(3'b100));
    tbl.push_back(idle(3'b000));
    tbl.push_back(mk(1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0, 4'h0, 3'b001));
    tbl.push_back(idle(3'b010));
    tbl.push_back(idle(3'b100));
    tbl.push_back(mk(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0, 4'h0, 3'b001));
    tbl.push_back(idle(3'b010));
    tbl.push_back(idle(3'b100));
    tbl.push_back(idle(3'b000));
    tbl.push_back(mk(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0, 4'h0, 3'b001));
    tbl.push_back(mk(1, 0, 5, 2'b10, 0, 0, 0, 0, 0, 1, 4'h0, 3'b010));
    tbl.push_back(mk(1, 0, 5, 2'b10, 0, 0, 0, 0, 0, 0, 4'h8, 3'b101));
    tbl.push_back(idle(3'b010));
    tbl.push_back(idle(3'b100));
    tbl.push_back(idle(3'b000));
    tbl.push_back(mk(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0, 4'h0, 3'b001));
    tbl.push_back(mk(1, 0, 5, 2'b10, 0, 0, 0, 1, 0, 0, 4'h0, 3'b010));
    tbl.push_back(idle(3'b100));
    tbl.push_back(idle(3'b000));
    tbl.push_back(mk(1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 4'h0, 3'b001));
    tbl.push_back(mk(1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 4'h0, 3'b011));
    tbl.push_back(mk(1, 0, 0, 2'b00, 7, 1, 1, 0, 0, 0, 4'h0, 3'b111));
    tbl.push_back(mk(1, 1, 7, 2'b01, 0, 0, 0, 0, 0, 0, 4'h0, 3'b111));
    tbl.push_back(mk(1, 0, 0, 2'b00, 4, 1, 0, 0, 0, 0, 4'h0, 3'b111));
    tbl.push_back(mk(1, 0, 0, 2'b00, 4, 1, 0, 0, 0, 0, 4'h0, 3'b111));
    tbl.push_back(mk(1, 4, 0, 2'b01, 0, 0, 0, 0, 0, 0, 4'h1, 3'b111));
    tbl.push_back(mk(1, 4, 4, 2'b11, 0, 0, 0, 0, 0, 0, 4'hA, 3'b111));

    foreach (tbl[k]) begin
      apply(tbl[k]);
      check($sformatf("tbl[%0d] stall", k), stall, tbl[k].e_stall);
      tick();
      check($sformatf("tbl[%0d] fwd_sel", k), fwd_sel, tbl[k].e_fwd);
      check($sformatf("tbl[%0d] stage_valid", k), stage_valid, tbl[k].e_sv);
    end

    // Hold: reference trace without hold, then the same trace with a 3-cycle hold.
    hseq.push_back(mk(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0, 0, 0));
    hseq.push_back(mk(1, 0, 5, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
    hseq.push_back(mk(1, 0, 5, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
    hseq.push_back(mk(1, 0, 0, 2'b00, 4, 1, 0, 0, 0, 0, 0, 0));
    hseq.push_back(mk(1, 0, 0, 2'b00, 4, 1, 0, 0, 0, 0, 0, 0));
    hseq.push_back(mk(1, 4, 5, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0));
    hseq.push_back(idle(0));
    hseq.push_back(idle(0));
    do_reset();
    foreach (hseq[k]) begin
      apply(hseq[k]);
      tick();
      ref_fwd[k] = model_fwd();
      ref_sv[k]  = model_sv();
      check("hold ref fwd_sel", fwd_sel, ref_fwd[k]);
      check("hold ref stage_valid", stage_valid, ref_sv[k]);
    end
    do_reset();
    foreach (hseq[k]) begin
      if (k == 2) begin
        for (int h = 0; h < 3; h++) begin
          vec_t hv = hseq[k];
          hv.hd = 1'b1;
          apply(hv);
          check("hold stall", stall, 0);
          tick();
          check("hold frozen fwd_sel", fwd_sel, ref_fwd[1]);
          check("hold frozen stage_valid", stage_valid, ref_sv[1]);
        end
      end
      apply(hseq[k]);
      tick();
      check("post-hold fwd_sel", fwd_sel, ref_fwd[k]);
      check("post-hold stage_valid", stage_valid, ref_sv[k]);
    end

    // DEPTH=4, LOAD_READY_STAGE=3: two stall cycles, then forward from stage 3.
    do_reset();
    apply(mk(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0, 0, 0));
    tick();
    check("d4 load stage_valid", stage_valid4, 4'b0001);
    apply(mk(1, 0, 5, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
    check("d4 stall cycle1", stall4, 1);
    tick();
    check("d4 bubble1 stage_valid", stage_valid4, 4'b0010);
    check("d4 stall cycle2", stall4, 1);
    tick();
    check("d4 bubble2 stage_valid", stage_valid4, 4'b0100);
    check("d4 stall released", stall4, 0);
    tick();
    check("d4 fwd_sel", fwd_sel4, 4'b1100);
    check("d4 consumer stage_valid", stage_valid4, 4'b1001);

    // Random run against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      vec_t rv;
      rv = mk($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
              0, 0, 0);
      reset = ($urandom_range(0, 99) == 0);
      apply(rv);
      check("rand stall", stall, model_stall());
      tick();
      check("rand fwd_sel", fwd_sel, model_fwd());
      check("rand stage_valid", stage_valid, model_sv());
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard unit for the in-order pipeline. It tracks the destination register, write-enable and load flag of every instruction in the DEPTH stages after decode. From that it produces a load-use stall and registered per-operand forwarding selects, for any number of source operands and any load-data latency. The datapath instantiates it between the decode and execute pipeline registers, replacing inline forwarding/stall logic.

Parameters:
REG_COUNT_BITS, 5, register-number width
DEPTH, 3, tracked post-decode stages (0=EX, 1=MEM, 2=WB, ...); minimum 2
NUM_SRC, 2, source operands per instruction
LOAD_READY_STAGE, 2, first stage index whose output carries load data; range 1..DEPTH-1
FWD_SEL_BITS, clog2(DEPTH), localparam, forward-select width

Ports:
clk  in  1  clock
reset  in  1  synchronous reset
issue_valid  in  1  decode holds a valid instruction
issue_src  in  NUM_SRC*REG_COUNT_BITS  source register numbers, operand i at [i*REG_COUNT_BITS +: REG_COUNT_BITS]
issue_src_used  in  NUM_SRC  operand i is actually read (0 for immediate operand)
issue_dst  in  REG_COUNT_BITS  destination register
issue_reg_write  in  1  instruction writes issue_dst
issue_is_load  in  1  result comes from memory
flush  in  1  branch/jump taken in EX; kill decode instruction
hold  in  1  external back-pressure; freeze all tracking state
stall  out  1  load-use hazard; fetch/decode must hold
fwd_sel  out  NUM_SRC*FWD_SEL_BITS  per operand, valid while the instruction is in stage 0: 0 = register-file value, k = result at output of stage k
stage_valid  out  DEPTH  occupancy of each tracked stage

Behaviour:
- Reset is synchronous and active-high. On reset, all stage entries are invalid, stage_valid=0, fwd_sel=0, and stall=0.
- Entry per stage: valid, dst, wr, load. wr is forced to 0 when dst==0. Register 0 never matches.
- Match for operand i at stage j: issue_src_used[i] and issue_valid and entry j valid and wr and dst==src_i. The youngest match (lowest j) wins.
- Forward select, computed in decode and registered with the instruction into stage 0:
  - For a winning j<=DEPTH-2, the select is j+1.
  - A match only at stage DEPTH-1 gives 0. The register file is write-first, so a same-cycle write is visible.
  - No match gives 0.
- stall (combinational) is 1 when any operand's winning match is a load with j+1<LOAD_READY_STAGE, with flush=0 and hold=0.
- The stall lasts until the producer reaches a stage at or beyond LOAD_READY_STAGE-1. With default parameters this is exactly 1 cycle.
- Each cycle with hold=0:
  - Entries shift j to j+1; the entry at DEPTH-1 retires.
  - Stage 0 is loaded from decode if issue_valid and not stall and not flush. Otherwise stage 0 becomes a bubble: invalid, fwd_sel=0.
- flush has priority over stall: a bubble is inserted and stall=0 that cycle, so fetch is free to redirect.
- hold=1: all entries and fwd_sel keep their value and stall=0. The decode/fetch freeze is the owner's responsibility. hold overrides flush; the caller must reassert flush after hold.
- Simultaneous reset and any other input: reset wins.
- Latency: fwd_sel is valid 1 cycle after the instruction is accepted from decode.

Decomposition:
- Shared package hazard_pkg:
  - FWD_RF=0 constant
  - clog2 function
  - stage-entry struct/typedef (valid, dst, wr, load)
- One sub-module, hazard_src_match: per-operand comparator, priority encoder and load-stall term, instantiated NUM_SRC times.

Test Plan:
- Reset: reset=1 for 2 cycles with issue_valid=1 -> stage_valid=000, stall=0, fwd_sel=0.
- ALU chain: issue dst=3, then next cycle src0=3 -> fwd_sel[0]=1. With one idle cycle in between -> 2. With two idle cycles -> 0. stall=0 throughout.
- Load-use: load dst=5, then src1=5 (used) -> stall=1 for exactly 1 cycle, stage_valid[0]=0 during the bubble, then fwd_sel[1]=2. With DEPTH=4, LOAD_READY_STAGE=3 -> stall 2 cycles, fwd_sel[1]=3.
- Flush: flush=1 during a load-use case -> stall=0 and stage_valid[0]=0 next cycle.
- Register 0 and unused operands:
  - dst=0 producer then src0=0 -> fwd_sel=0, stall=0.
  - Load dst=7 then src1=7 with issue_src_used[1]=0 -> no stall.
- Youngest and hold: r4 written by both stage0 and stage1 entries -> fwd_sel=1. hold=1 for 3 cycles mid-sequence -> stage_valid and fwd_sel frozen. The trace after release matches the no-hold trace.
